// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state encoding, opcode/funct constants and ALU op codes for the multicycle controller
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEXE = 4'd9,
    S_JUMP    = 4'd10,
    S_JAL     = 4'd11,
    S_JR      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // Codes understood by the existing datapath ALU
  localparam logic [4:0] ALU_AND = 5'd0;
  localparam logic [4:0] ALU_OR  = 5'd1;
  localparam logic [4:0] ALU_ADD = 5'd2;
  localparam logic [4:0] ALU_SUB = 5'd6;
  localparam logic [4:0] ALU_SLT = 5'd7;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational R-type funct to ALU operation decode
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [4:0] alu_control,
  output logic       valid
);

  always_comb begin
    alu_control = ALU_ADD;
    valid       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-subset control FSM with retired-instruction counter
module multicycle_control
  import mc_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                memReady,
  output logic                memRead,
  output logic                memWrite,
  output logic                iOrD,
  output logic                irWrite,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic                regWrite,
  output logic [1:0]          regDst,
  output logic [1:0]          memToReg,
  output logic                aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic [4:0]          aluControl,
  output logic [1:0]          pcSrc,
  output logic [3:0]          state,
  output logic                illegalOp,
  output logic [RETIRE_W-1:0] retired
);

  state_t     state_q, state_d;
  logic [4:0] rt_control;
  logic       rt_valid;

  alu_decoder u_alu_decoder (
    .funct       (funct),
    .alu_control (rt_control),
    .valid       (rt_valid)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      state_q <= state_d;
      // An illegal-op exit also lands in FETCH but did not complete an instruction
      if (state_q != S_FETCH && state_d == S_FETCH && !illegalOp)
        retired <= retired + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    iOrD        = 1'b0;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    regWrite    = 1'b0;
    regDst      = 2'd0;
    memToReg    = 2'd0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'd0;
    aluControl  = ALU_ADD;
    pcSrc       = 2'd0;
    illegalOp   = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'd1;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        aluSrcB = 2'd3;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_RTEXE;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEXE;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegalOp = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'd2;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iOrD    = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 2'd1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iOrD     = 1'b1;
        if (memReady) state_d = S_FETCH;
      end
      S_RTEXE: begin
        aluSrcA    = 1'b1;
        aluControl = rt_control;
        if (rt_valid) begin
          state_d = S_ALUWB;
        end else begin
          illegalOp = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_ALUWB: begin
        // Shared by R-type (rd) and addi (rt)
        regWrite = 1'b1;
        regDst   = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        aluSrcA     = 1'b1;
        aluControl  = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSrc       = 2'd1;
        state_d     = S_FETCH;
      end
      S_ADDIEXE: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'd2;
        state_d = S_ALUWB;
      end
      S_JUMP: begin
        pcWrite = 1'b1;
        pcSrc   = 2'd2;
        state_d = S_FETCH;
      end
      S_JAL: begin
        pcWrite  = 1'b1;
        pcSrc    = 2'd2;
        regWrite = 1'b1;
        regDst   = 2'd2;
        memToReg = 2'd2;
        state_d  = S_FETCH;
      end
      S_JR: begin
        pcWrite = 1'b1;
        pcSrc   = 2'd3;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       resetN;
  logic [5:0] opcode, funct;
  logic       zero, memReady;

  logic memRead, memWrite, iOrD, irWrite, pcWrite, pcWriteCond, regWrite, aluSrcA, illegalOp;
  logic [1:0] regDst, memToReg, aluSrcB, pcSrc;
  logic [4:0] aluControl;
  logic [3:0] state;
  logic [31:0] retired;

  logic n_memRead, n_memWrite, n_iOrD, n_irWrite, n_pcWrite, n_pcWriteCond, n_regWrite, n_aluSrcA, n_illegalOp;
  logic [1:0] n_regDst, n_memToReg, n_aluSrcB, n_pcSrc;
  logic [4:0] n_aluControl;
  logic [3:0] n_state;
  logic [3:0] n_retired;

  int n_cmp = 0;
  int n_bad = 0;
  int pc_upd;

  always #5 clock = ~clock;

  multicycle_control dut (
    .clock(clock), .resetN(resetN), .opcode(opcode), .funct(funct), .zero(zero),
    .memReady(memReady), .memRead(memRead), .memWrite(memWrite), .iOrD(iOrD),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .regWrite(regWrite),
    .regDst(regDst), .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluControl(aluControl), .pcSrc(pcSrc), .state(state), .illegalOp(illegalOp),
    .retired(retired)
  );

  multicycle_control #(.RETIRE_W(4)) dut_narrow (
    .clock(clock), .resetN(resetN), .opcode(opcode), .funct(funct), .zero(zero),
    .memReady(memReady), .memRead(n_memRead), .memWrite(n_memWrite), .iOrD(n_iOrD),
    .irWrite(n_irWrite), .pcWrite(n_pcWrite), .pcWriteCond(n_pcWriteCond), .regWrite(n_regWrite),
    .regDst(n_regDst), .memToReg(n_memToReg), .aluSrcA(n_aluSrcA), .aluSrcB(n_aluSrcB),
    .aluControl(n_aluControl), .pcSrc(n_pcSrc), .state(n_state), .illegalOp(n_illegalOp),
    .retired(n_retired)
  );

  // Bench-side PC: counts the edges on which the PC register would load
  always @(posedge clock or negedge resetN) begin
    if (!resetN) pc_upd <= 0;
    else if (pcWrite || (pcWriteCond && zero)) pc_upd <= pc_upd + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Completes a fetch in one cycle; leaves the DUT in DECODE
  task automatic run_fetch(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct = fn;
    memReady = 1'b1;
    #1;
    tick();
    memReady = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    resetN = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; memReady = 1'b0;
    #2;
    n_cmp++;
    if ({state, illegalOp, memRead, irWrite} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL reset_state: got %b want %b", {state, illegalOp, memRead, irWrite}, 7'b0000010);
    end
    n_cmp++;
    if (retired !== 32'd0) begin
      n_bad++; $display("FAIL reset_retired: got %0d want 0", retired);
    end
    tick();
    resetN = 1'b1;
    #1;
  endtask

  task automatic test_lw;
    opcode = 6'b100011; funct = 6'd0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) memReady = 1'b1;
      #1;
      n_cmp++;
      if ({state, irWrite, pcWrite} !== {4'd0, (i == 3), (i == 3)}) begin
        n_bad++; $display("FAIL lw_fetch%0d: got %b want %b", i, {state, irWrite, pcWrite}, {4'd0, (i == 3), (i == 3)});
      end
      tick();
    end
    memReady = 1'b0;
    #1;
    n_cmp++;
    if ({state, aluSrcA, aluSrcB} !== {4'd1, 1'b0, 2'd3}) begin
      n_bad++; $display("FAIL lw_decode: got %b want %b", {state, aluSrcA, aluSrcB}, 7'b0001011);
    end
    tick();
    n_cmp++;
    if ({state, aluSrcA, aluSrcB, aluControl} !== {4'd2, 1'b1, 2'd2, 5'd2}) begin
      n_bad++; $display("FAIL lw_memadr: got %b want %b", {state, aluSrcA, aluSrcB, aluControl}, {4'd2, 1'b1, 2'd2, 5'd2});
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) memReady = 1'b1;
      #1;
      n_cmp++;
      if ({state, memRead, iOrD} !== {4'd3, 1'b1, 1'b1}) begin
        n_bad++; $display("FAIL lw_memrd%0d: got %b want %b", i, {state, memRead, iOrD}, 6'b001111);
      end
      tick();
    end
    memReady = 1'b0;
    #1;
    n_cmp++;
    if ({state, regWrite, regDst, memToReg, retired} !== {4'd4, 1'b1, 2'd0, 2'd1, 32'd0}) begin
      n_bad++; $display("FAIL lw_memwb: got state %0d rw %b rd %0d m2r %0d ret %0d", state, regWrite, regDst, memToReg, retired);
    end
    tick();
    n_cmp++;
    if ({state, retired} !== {4'd0, 32'd1}) begin
      n_bad++; $display("FAIL lw_retire: got state %0d ret %0d want 0 / 1", state, retired);
    end
  endtask

  task automatic test_beq(input logic z);
    int pc0;
    run_fetch(6'b000100, 6'd0);
    tick();
    zero = z;
    #1;
    pc0 = pc_upd;
    n_cmp++;
    if ({state, pcWriteCond, pcSrc, pcWrite, aluControl} !== {4'd8, 1'b1, 2'd1, 1'b0, 5'd6}) begin
      n_bad++; $display("FAIL beq_strobes_z%0b: got %b want %b", z, {state, pcWriteCond, pcSrc, pcWrite, aluControl}, {4'd8, 1'b1, 2'd1, 1'b0, 5'd6});
    end
    tick();
    zero = 1'b0;
    n_cmp++;
    if ({state, pc_upd} !== {4'd0, pc0 + (z ? 1 : 0)}) begin
      n_bad++; $display("FAIL beq_pc_z%0b: got state %0d pc_loads %0d want 0 / %0d", z, state, pc_upd, pc0 + (z ? 1 : 0));
    end
  endtask

  task automatic test_jumps;
    run_fetch(6'b000011, 6'd0);
    tick();
    n_cmp++;
    if ({state, regDst, memToReg, regWrite, pcWrite, pcSrc} !== {4'd11, 2'd2, 2'd2, 1'b1, 1'b1, 2'd2}) begin
      n_bad++; $display("FAIL jal: got %b want %b", {state, regDst, memToReg, regWrite, pcWrite, pcSrc}, {4'd11, 2'd2, 2'd2, 1'b1, 1'b1, 2'd2});
    end
    tick();
    n_cmp++;
    if (state !== 4'd0) begin
      n_bad++; $display("FAIL jal_single: got state %0d want 0", state);
    end
    run_fetch(6'b000010, 6'd0);
    tick();
    n_cmp++;
    if ({state, pcWrite, pcSrc, regWrite} !== {4'd10, 1'b1, 2'd2, 1'b0}) begin
      n_bad++; $display("FAIL jump: got %b want %b", {state, pcWrite, pcSrc, regWrite}, {4'd10, 1'b1, 2'd2, 1'b0});
    end
    tick();
    run_fetch(6'b000000, 6'b001000);
    tick();
    n_cmp++;
    if ({state, pcWrite, pcSrc} !== {4'd12, 1'b1, 2'd3}) begin
      n_bad++; $display("FAIL jr: got %b want %b", {state, pcWrite, pcSrc}, {4'd12, 1'b1, 2'd3});
    end
    tick();
  endtask

  task automatic test_rtype;
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [4:0] ops [5] = '{5'd2, 5'd6, 5'd0, 5'd1, 5'd7};
    for (int i = 0; i < 5; i++) begin
      run_fetch(6'b000000, fns[i]);
      tick();
      n_cmp++;
      if ({state, aluSrcA, aluSrcB, aluControl} !== {4'd6, 1'b1, 2'd0, ops[i]}) begin
        n_bad++; $display("FAIL rtexe_%0d: got %b want %b", i, {state, aluSrcA, aluSrcB, aluControl}, {4'd6, 1'b1, 2'd0, ops[i]});
      end
      tick();
      n_cmp++;
      if ({state, regWrite, regDst, memToReg} !== {4'd7, 1'b1, 2'd1, 2'd0}) begin
        n_bad++; $display("FAIL aluwb_r%0d: got %b want %b", i, {state, regWrite, regDst, memToReg}, {4'd7, 1'b1, 2'd1, 2'd0});
      end
      tick();
    end
    run_fetch(6'b001000, 6'd0);
    tick();
    n_cmp++;
    if ({state, aluSrcA, aluSrcB, aluControl} !== {4'd9, 1'b1, 2'd2, 5'd2}) begin
      n_bad++; $display("FAIL addiexe: got %b want %b", {state, aluSrcA, aluSrcB, aluControl}, {4'd9, 1'b1, 2'd2, 5'd2});
    end
    tick();
    n_cmp++;
    if ({state, regWrite, regDst} !== {4'd7, 1'b1, 2'd0}) begin
      n_bad++; $display("FAIL aluwb_addi: got %b want %b", {state, regWrite, regDst}, {4'd7, 1'b1, 2'd0});
    end
    tick();
  endtask

  task automatic test_illegal;
    logic [31:0] r0;
    r0 = retired;
    run_fetch(6'b111111, 6'd0);
    n_cmp++;
    if ({state, illegalOp} !== {4'd1, 1'b1}) begin
      n_bad++; $display("FAIL illegal_op_pulse: got %b want %b", {state, illegalOp}, 5'b00011);
    end
    tick();
    n_cmp++;
    if ({state, illegalOp, retired} !== {4'd0, 1'b0, r0}) begin
      n_bad++; $display("FAIL illegal_op_exit: got state %0d ill %b ret %0d want 0 0 %0d", state, illegalOp, retired, r0);
    end
    run_fetch(6'b000000, 6'b111111);
    tick();
    n_cmp++;
    if ({state, illegalOp} !== {4'd6, 1'b1}) begin
      n_bad++; $display("FAIL illegal_funct_pulse: got %b want %b", {state, illegalOp}, 5'b01101);
    end
    tick();
    n_cmp++;
    if ({state, illegalOp, retired} !== {4'd0, 1'b0, r0}) begin
      n_bad++; $display("FAIL illegal_funct_exit: got state %0d ill %b ret %0d want 0 0 %0d", state, illegalOp, retired, r0);
    end
  endtask

  task automatic test_reset_memwr;
    run_fetch(6'b101011, 6'd0);
    tick();
    tick();
    n_cmp++;
    if ({state, memWrite, iOrD, memRead} !== {4'd5, 1'b1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL memwr_wait: got %b want %b", {state, memWrite, iOrD, memRead}, 7'b0101110);
    end
    #2;
    resetN = 1'b0;
    #1;
    n_cmp++;
    if ({state, memWrite, illegalOp, retired} !== {4'd0, 1'b0, 1'b0, 32'd0}) begin
      n_bad++; $display("FAIL async_reset: got state %0d mw %b ill %b ret %0d want 0 0 0 0", state, memWrite, illegalOp, retired);
    end
    tick();
    resetN = 1'b1;
    #1;
  endtask

  task automatic test_wrap;
    for (int k = 0; k < 16; k++) begin
      run_fetch(6'b000000, 6'b100000);
      tick();
      tick();
      tick();
      if (k == 14) begin
        n_cmp++;
        if (n_retired !== 4'd15) begin
          n_bad++; $display("FAIL wrap_15: got %0d want 15", n_retired);
        end
      end
    end
    n_cmp++;
    if ({n_retired, retired} !== {4'd0, 32'd16}) begin
      n_bad++; $display("FAIL wrap_0: got narrow %0d wide %0d want 0 / 16", n_retired, retired);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jumps();
    test_rtype();
    test_illegal();
    test_reset_memwr();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
